// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit arbiter slice.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int   DEF_DATA_W  = 8;
  localparam int   FRAME_BITS  = DEF_DATA_W + 2;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic int frame_cycles(input int data_w, input int clks_per_bit);
    return (data_w + 2) * clks_per_bit;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side request bundle: per-requester level req, packed bytes, one-cycle ack.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        ack;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start pulse loads a byte, tx is registered, done pulses on the
// last stop-bit cycle so the caller can re-arbitrate after one idle cycle.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              done,
  output logic              tx
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [BIT_W-1:0]  bit_idx, bit_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              tx_nxt;
  logic              last;

  assign last = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= IDLE_LEVEL;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = tx;
    done      = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = IDLE_LEVEL;
        if (start) begin
          state_nxt = START;
          cnt_nxt   = '0;
          shift_nxt = din;
          tx_nxt    = START_LEVEL;
        end
      end
      START: begin
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
          tx_nxt    = shift[0];
          shift_nxt = shift >> 1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (last) begin
          cnt_nxt = '0;
          if (bit_idx == BIT_W'(DATA_W - 1)) begin
            bit_nxt   = '0;
            state_nxt = STOP;
            tx_nxt    = IDLE_LEVEL;
          end else begin
            bit_nxt   = bit_idx + BIT_W'(1);
            tx_nxt    = shift[0];
            shift_nxt = shift >> 1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          tx_nxt    = IDLE_LEVEL;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART tx line among N_REQ producers; grant only while idle,
// ack is a registered one-hot pulse in the same cycle the start bit begins.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus,
  output logic             busy,
  output logic             tx
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr, gnt_idx, ptr_nxt;
  logic              gnt_vld, start, done;
  logic [N_REQ-1:0]  ack_nxt;
  logic [DATA_W-1:0] gnt_dat;

  // First pending requester at or above the pointer, wrapping around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_vld && bus.req[(int'(rr_ptr) + i) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  assign start   = gnt_vld && !busy;
  assign gnt_dat = bus.data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign ptr_nxt = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  always_comb begin
    ack_nxt = '0;
    if (start) ack_nxt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      busy    <= 1'b0;
      bus.ack <= '0;
    end else begin
      bus.ack <= ack_nxt;
      if (start) begin
        busy   <= 1'b1;
        rr_ptr <= ptr_nxt;
      end else if (done) begin
        busy <= 1'b0;
      end
    end
  end

  uart_tx_serializer #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (gnt_dat),
    .done  (done),
    .tx    (tx)
  );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N_REQ=4, CLKS_PER_BIT=4.
module tb_uart_tx_arbiter;
  logic clk;
  logic rst;
  logic busy;
  logic tx;
  int   checks;
  int   errors;
  int   w;

  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(
    .N_REQ        (4),
    .DATA_W       (8),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {bus.ack, busy, tx}, 32'b0000_0_1);
  endtask

  // Steps at least once, then until any ack or the budget runs out.
  task automatic wait_ack(input logic [3:0] exp, input int budget, input string tag,
                          output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.ack == 4'b0 && waited < budget);
    chk(tag, bus.ack, exp);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Called in the ack cycle; checks every cycle of the 40-cycle frame.
  task automatic chk_frame(input logic [7:0] b, input bit pulse3, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (pulse3 && i == 5) bus.req[3] = 1'b1;
      if (pulse3 && i == 6) bus.req[3] = 1'b0;
      chk({tag, "_tx"}, tx, f[i/4]);
      if (i == 0 || i == 39) chk({tag, "_busy"}, busy, 1'b1);
      if (i == 1) chk({tag, "_ack_pulse"}, bus.ack, 4'b0);
    end
    @(negedge clk);
    chk({tag, "_end"}, {busy, tx}, 2'b01);
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    checks   = 0;
    errors   = 0;
    bus.req  = '0;
    bus.data = '0;

    // 1. reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t1_idle", {bus.ack, busy, tx}, 32'b0000_0_1);
    end

    // 2. single request, 8'hA5 from requester 1
    bus.data[15:8] = 8'hA5;
    bus.req        = 4'b0010;
    wait_ack(4'b0010, 5, "t2_ack", w);
    chk("t2_ack_lat", w, 1);
    bus.req = '0;
    chk_frame(8'hA5, 1'b0, "t2");

    // 3. round robin from a freshly reset pointer
    do_reset();
    bus.data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req  = 4'b1111;
    wait_ack(4'b0001, 5, "t3_ack0", w);
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] exp;
      exp     = 4'b0001 << (k % 4);
      bus.req = 4'b1111 & ~bus.ack;
      @(negedge clk);
      bus.req = 4'b1111;
      wait_ack(exp, 60, "t3_ack_order", w);
      chk("t3_ack_gap", w + 1, 41);
    end
    bus.req = '0;
    wait_idle(60, "t3_idle");

    // 4. requester 0 raised mid-frame of requester 2
    bus.req = 4'b0100;
    wait_ack(4'b0100, 5, "t4_ack2", w);
    bus.req = '0;
    repeat (10) @(negedge clk);
    bus.req[0] = 1'b1;
    wait_ack(4'b0001, 60, "t4_ack0", w);
    chk("t4_wait", w, 31);

    // 6. byte changed after ack, req3 pulsed while busy
    bus.req[0]    = 1'b0;
    bus.data[7:0] = 8'h00;
    chk_frame(8'h11, 1'b1, "t6");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_ack3", bus.ack, 4'b0);
    end

    // 5. reset during data bit 3 of 8'hFF
    bus.data[15:8] = 8'hFF;
    bus.req        = 4'b0010;
    wait_ack(4'b0010, 5, "t5_ack1", w);
    bus.req = '0;
    repeat (17) @(negedge clk);
    chk("t5_bit3", {busy, tx}, 2'b11);
    rst     = 1'b1;
    bus.req = 4'b1000;
    @(negedge clk);
    chk("t5_reset", {bus.ack, busy, tx}, 32'b0000_0_1);
    rst = 1'b0;
    wait_ack(4'b1000, 5, "t5_ack3", w);
    chk("t5_ack_lat", w, 1);
    bus.req = '0;
    chk_frame(8'h44, 1'b0, "t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
